demux_n_route: RTL and testbench

// - Registered 1-to-NUM_CH demultiplexer with per-destination backpressure. Successor to the 2-way combinational demux.
// - Routes each accepted word to one output channel. The channel is chosen by a selector field inside the word (vc_id / dest bits).
// - Sits between an upstream FIFO pop side and NUM_CH downstream FIFO push sides.
// - Stalls on a full destination instead of dropping the word.

---
 rtl/demux_n_route.sv | 127 ++++++++++++
 tb/tb_demux_n_route.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demux_n_route.sv
// Registered 1-to-NUM_CH demultiplexer with per-destination backpressure and a one-word hold stage.
// Optional per-channel push and stall counters are built when DEMUX_N_ROUTE_STATS_EN is defined.
module demux_n_route #(
   parameter int unsigned DATA_SIZE = 6,
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned SEL_LSB   = 4,
   parameter int unsigned SEL_W     = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_in,
   input  logic [DATA_SIZE-1:0]          data_in,
   output logic                          ready_out,
   input  logic [NUM_CH-1:0]             full_in,
   output logic [NUM_CH-1:0]             push,
   output logic [NUM_CH*DATA_SIZE-1:0]   data_out,
   output logic                          sel_err
`ifdef DEMUX_N_ROUTE_STATS_EN
   ,
   output logic [NUM_CH*8-1:0]           cnt_push,
   output logic [7:0]                    cnt_stall
`endif
);

   localparam int unsigned NSEL   = 1 << SEL_W;
   localparam int unsigned SELX_W = SEL_W + 1;

   typedef enum logic {RUN, STALL} state_t;

   state_t                      state, state_nx;
   logic [SEL_W-1:0]            sel, tgt, hold_sel, hold_sel_nx;
   logic [DATA_SIZE-1:0]        hold, hold_nx, word;
   logic [NSEL-1:0]             full_pad;
   logic                        sel_ok, go, sel_err_nx;
   logic [NUM_CH-1:0]           push_nx;
   logic [NUM_CH*DATA_SIZE-1:0] data_nx;

   assign sel       = data_in[SEL_LSB +: SEL_W];
   assign sel_ok    = {1'b0, sel} < SELX_W'(NUM_CH);
   assign full_pad  = NSEL'(full_in);
   assign ready_out = (state == RUN);

   // Next-state: route, capture into hold on a full destination, or drain the hold.
   always_comb begin
      state_nx    = state;
      hold_nx     = hold;
      hold_sel_nx = hold_sel;
      sel_err_nx  = sel_err;
      go          = 1'b0;
      word        = data_in;
      tgt         = sel;
      unique case (state)
         RUN: begin
            if (valid_in) begin
               if (!sel_ok) begin
                  sel_err_nx = 1'b1;
               end else if (full_pad[sel]) begin
                  hold_nx     = data_in;
                  hold_sel_nx = sel;
                  state_nx    = STALL;
               end else begin
                  go = 1'b1;
               end
            end
         end
         STALL: begin
            word = hold;
            tgt  = hold_sel;
            if (!full_pad[hold_sel]) begin
               go       = 1'b1;
               state_nx = RUN;
            end
         end
      endcase
   end

   // One-hot push decode; every non-pushed slice is zeroed.
   always_comb begin
      push_nx = '0;
      data_nx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (go && (tgt == SEL_W'(k))) begin
            push_nx[k]                          = 1'b1;
            data_nx[k*DATA_SIZE +: DATA_SIZE]   = word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         push     <= '0;
         data_out <= '0;
         sel_err  <= 1'b0;
         hold     <= '0;
         hold_sel <= '0;
      end else begin
         push     <= push_nx;
         data_out <= data_nx;
         sel_err  <= sel_err_nx;
         hold     <= hold_nx;
         hold_sel <= hold_sel_nx;
      end
   end

`ifdef DEMUX_N_ROUTE_STATS_EN
   // Saturating event counters, updated on the edge that decides the event.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_push  <= '0;
         cnt_stall <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (push_nx[k] && (cnt_push[k*8 +: 8] != 8'hFF))
               cnt_push[k*8 +: 8] <= cnt_push[k*8 +: 8] + 8'd1;
         end
         if ((state == STALL) && (cnt_stall != 8'hFF))
            cnt_stall <= cnt_stall + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_demux_n_route.sv
// Bench for demux_n_route: a 4-channel and a 3-channel instance share stimulus and are checked
// against a word-level reference model (pending word + per-channel delivery).
module tb_demux_n_route;

   logic        clk = 1'b0;
   logic        reset, valid_in;
   logic [5:0]  data_in;
   logic [3:0]  full_in;
   logic        rdy4, rdy3, err4, err3;
   logic [3:0]  push4;
   logic [2:0]  push3;
   logic [23:0] dout4;
   logic [17:0] dout3;
`ifdef DEMUX_N_ROUTE_STATS_EN
   logic [31:0] cp4;
   logic [23:0] cp3;
   logic [7:0]  cs4, cs3;
`endif

   int n_vec = 0;
   int n_err = 0;
   bit init_done = 0;

   // reference model state, index 0 = 4-channel build, 1 = 3-channel build
   int          nch [2] = '{4, 3};
   bit          pend_v [2];
   logic [5:0]  pend_d [2];
   logic [3:0]  e_push [2];
   logic [23:0] e_dout [2];
   bit          e_err  [2];
   int          cnt_p  [2][4];
   int          cnt_s  [2];

   always #5 clk = ~clk;

   demux_n_route #(.DATA_SIZE(6), .NUM_CH(4), .SEL_LSB(4), .SEL_W(2)) u_dut4 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
      .ready_out(rdy4), .full_in(full_in), .push(push4), .data_out(dout4),
      .sel_err(err4)
`ifdef DEMUX_N_ROUTE_STATS_EN
      , .cnt_push(cp4), .cnt_stall(cs4)
`endif
   );

   demux_n_route #(.DATA_SIZE(6), .NUM_CH(3), .SEL_LSB(4), .SEL_W(2)) u_dut3 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
      .ready_out(rdy3), .full_in(full_in[2:0]), .push(push3), .data_out(dout3),
      .sel_err(err3)
`ifdef DEMUX_N_ROUTE_STATS_EN
      , .cnt_push(cp3), .cnt_stall(cs3)
`endif
   );

   function automatic int sat(input int x);
      return (x > 255) ? 255 : x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic deliver(input int i, input int s, input logic [5:0] w);
      e_push[i] = 4'(1 << s);
      e_dout[i] = 24'(w) << (s * 6);
      cnt_p[i][s]++;
   endtask

   // what one clock edge does, in terms of words and channels
   task automatic model_edge(input int i);
      int s;
      e_push[i] = '0;
      e_dout[i] = '0;
      if (reset) begin
         pend_v[i] = 0;
         e_err[i]  = 0;
         cnt_s[i]  = 0;
         for (int k = 0; k < 4; k++) cnt_p[i][k] = 0;
      end else if (pend_v[i]) begin
         cnt_s[i]++;
         s = int'(pend_d[i][5:4]);
         if (!full_in[s]) begin
            deliver(i, s, pend_d[i]);
            pend_v[i] = 0;
         end
      end else if (valid_in) begin
         s = int'(data_in[5:4]);
         if (s >= nch[i]) e_err[i] = 1;
         else if (full_in[s]) begin
            pend_v[i] = 1;
            pend_d[i] = data_in;
         end else deliver(i, s, data_in);
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [5:0] d, input logic [3:0] f);
      reset = r; valid_in = v; data_in = d; full_in = f;
      #1;
      if (init_done) begin
         chk("ready4", 32'(rdy4), 32'(!pend_v[0]));
         chk("ready3", 32'(rdy3), 32'(!pend_v[1]));
      end
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      init_done = 1;
      chk("push4", 32'(push4), 32'(e_push[0]));
      chk("dout4", 32'(dout4), 32'(e_dout[0]));
      chk("err4",  32'(err4),  32'(e_err[0]));
      chk("push3", 32'(push3), 32'(e_push[1]));
      chk("dout3", 32'(dout3), 32'(e_dout[1]));
      chk("err3",  32'(err3),  32'(e_err[1]));
      n_vec++;
   endtask

   initial begin
      logic [5:0] w;
      reset = 1'b1; valid_in = 1'b0; data_in = '0; full_in = '0;

      // reset held two cycles with valid high
      step(1, 1, 6'h15, 4'h0);
      step(1, 1, 6'h15, 4'h0);
      chk("rst_push", 32'(push4), 32'h0);
      chk("rst_dout", 32'(dout4), 32'h0);
      chk("rst_err",  32'(err4),  32'h0);
      #1 reset = 1'b0;
      #1 chk("rst_ready", 32'(rdy4), 32'h1);

      // back-to-back routing to each channel
      for (int k = 0; k < 4; k++) begin
         w = 6'(k * 16 + 5);
         step(0, 1, w, 4'h0);
         chk("route_push", 32'(push4), 32'(1 << k));
         chk("route_data", 32'(dout4[k*6 +: 6]), 32'(w));
      end

      // stall on ch2 for three cycles, then drain
      step(0, 1, 6'h2A, 4'b0100);
      chk("stall_nopush", 32'(push4), 32'h0);
      for (int k = 0; k < 2; k++) begin
         step(0, 1, 6'($urandom), 4'b0100);
         chk("stall_nopush", 32'(push4), 32'h0);
      end
      chk("stall_ready", 32'(rdy4), 32'h0);
      step(0, 1, 6'h07, 4'b0000);
      chk("drain_push", 32'(push4), 32'b0100);
      chk("drain_data", 32'(dout4[12 +: 6]), 32'h2A);
      #1 chk("drain_ready", 32'(rdy4), 32'h1);

      // invalid selector on the 3-channel build
      step(1, 0, 6'h00, 4'h0);
      chk("err3_clr", 32'(err3), 32'h0);
      step(0, 1, 6'h3F, 4'h0);
      chk("bad_push3", 32'(push3), 32'h0);
      chk("bad_err3", 32'(err3), 32'h1);
      step(0, 1, 6'h01, 4'h0);
      chk("after_bad_push3", 32'(push3), 32'b001);
      chk("err3_sticky", 32'(err3), 32'h1);

      // reset while stalled on ch1 drops the held word
      step(0, 1, 6'h1B, 4'b0010);
      step(0, 1, 6'h00, 4'b0010);
      chk("rs_stall_ready", 32'(rdy4), 32'h0);
      step(1, 0, 6'h00, 4'b0000);
      #1 reset = 1'b0;
      #1 chk("rs_ready", 32'(rdy4), 32'h1);
      step(0, 0, 6'h00, 4'b0000);
      chk("rs_push", 32'(push4), 32'h0);

      // random traffic with sparse backpressure
      for (int n = 0; n < 400; n++) begin
         step(0, $urandom_range(0, 3) != 0, 6'($urandom),
              ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
      end

`ifdef DEMUX_N_ROUTE_STATS_EN
      for (int k = 0; k < 4; k++) begin
         chk("cnt_push4", 32'(cp4[k*8 +: 8]), 32'(sat(cnt_p[0][k])));
         if (k < 3) chk("cnt_push3", 32'(cp3[k*8 +: 8]), 32'(sat(cnt_p[1][k])));
      end
      chk("cnt_stall4", 32'(cs4), 32'(sat(cnt_s[0])));
      chk("cnt_stall3", 32'(cs3), 32'(sat(cnt_s[1])));
      step(1, 0, 6'h00, 4'h0);
      for (int n = 0; n < 300; n++) step(0, 1, 6'h30 | 6'($urandom_range(0, 15)), 4'h0);
      step(0, 0, 6'h00, 4'h0);
      chk("cnt_push4_sat", 32'(cp4[24 +: 8]), 32'd255);
      chk("cnt_stall4_end", 32'(cs4), 32'(sat(cnt_s[0])));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
